spi_ram_mem: RTL and testbench

//  Single-port command-driven RAM downstream of the SPI slave. Consumes each 10-bit word the slave

---
 rtl/shared_pkg.sv | 15 +
 rtl/spi_ram_array.sv | 29 ++
 rtl/spi_ram_mem.sv | 127 ++++++++++++
 tb/tb_spi_ram_mem.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/shared_pkg.sv
// Shared sizing and command encoding for the SPI slave / RAM pair.
package shared_pkg;

  localparam int MEM_DEPTH = 256;
  localparam int ADDR_SIZE = $clog2(MEM_DEPTH);
  localparam int MEM_WIDTH = 8;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } ram_cmd_e;

endpackage

// File: rtl/spi_ram_array.sv
// Plain single-clock storage: one write port and one registered read port, no reset.
module spi_ram_array
  import shared_pkg::*;
(
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [MEM_WIDTH-1:0] wdata,
  input  logic                 re,
  input  logic [ADDR_SIZE-1:0] raddr,
  output logic [MEM_WIDTH-1:0] rdata
);

  logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];
  logic [MEM_WIDTH-1:0] rdata_q;

  // Storage write and registered read; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/spi_ram_mem.sv
// Command decoder and address/valid bookkeeping for the SPI RAM.
// Optional macro RAM_AUTO_INC_EN: post-increment addresses after accepted data commands.
module spi_ram_mem
  import shared_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MEM_WIDTH+1:0] rx_data,
  input  logic                 rx_valid,
  output logic [MEM_WIDTH-1:0] tx_data,
  output logic                 tx_valid,
  output logic                 seq_err
);

  ram_cmd_e             cmd;
  logic [ADDR_SIZE-1:0] wr_addr_d, wr_addr_q;
  logic [ADDR_SIZE-1:0] rd_addr_d, rd_addr_q;
  logic                 wr_addr_vld_d, wr_addr_vld_q;
  logic                 rd_addr_vld_d, rd_addr_vld_q;
  logic                 tx_valid_d, tx_valid_q;
  logic                 seq_err_d, seq_err_q;
  logic [MEM_WIDTH-1:0] tx_hold_d, tx_hold_q;
  logic                 mem_we, mem_re;
  logic [MEM_WIDTH-1:0] mem_rdata;

  assign cmd = ram_cmd_e'(rx_data[MEM_WIDTH+1:MEM_WIDTH]);

  // Command decode and next-state for addresses, flags and pulses.
  always_comb begin
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    wr_addr_vld_d = wr_addr_vld_q;
    rd_addr_vld_d = rd_addr_vld_q;
    tx_valid_d    = 1'b0;
    seq_err_d     = 1'b0;
    mem_we        = 1'b0;
    mem_re        = 1'b0;
    if (rx_valid) begin
      case (cmd)
        WR_ADDR: begin
          wr_addr_d     = rx_data[ADDR_SIZE-1:0];
          wr_addr_vld_d = 1'b1;
        end
        WR_DATA: begin
          if (wr_addr_vld_q) begin
            mem_we = 1'b1;
`ifdef RAM_AUTO_INC_EN
            wr_addr_d = wr_addr_q + {{(ADDR_SIZE-1){1'b0}}, 1'b1};
`else
            wr_addr_d = wr_addr_q;
`endif
          end else begin
            seq_err_d = 1'b1;
          end
        end
        RD_ADDR: begin
          rd_addr_d     = rx_data[ADDR_SIZE-1:0];
          rd_addr_vld_d = 1'b1;
        end
        RD_DATA: begin
          if (rd_addr_vld_q) begin
            mem_re     = 1'b1;
            tx_valid_d = 1'b1;
`ifdef RAM_AUTO_INC_EN
            rd_addr_d = rd_addr_q + {{(ADDR_SIZE-1){1'b0}}, 1'b1};
`else
            rd_addr_d = rd_addr_q;
`endif
          end else begin
            seq_err_d = 1'b1;
          end
        end
        default: begin
          seq_err_d = 1'b0;
        end
      endcase
    end else begin
      seq_err_d = 1'b0;
    end
  end

  // The array's read register is not reset, so a reset-clean copy holds the last result.
  always_comb begin
    tx_hold_d = tx_hold_q;
    if (tx_valid_q) begin
      tx_hold_d = mem_rdata;
    end else begin
      tx_hold_d = tx_hold_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr_q     <= {ADDR_SIZE{1'b0}};
      rd_addr_q     <= {ADDR_SIZE{1'b0}};
      wr_addr_vld_q <= 1'b0;
      rd_addr_vld_q <= 1'b0;
      tx_valid_q    <= 1'b0;
      seq_err_q     <= 1'b0;
      tx_hold_q     <= {MEM_WIDTH{1'b0}};
    end else begin
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      wr_addr_vld_q <= wr_addr_vld_d;
      rd_addr_vld_q <= rd_addr_vld_d;
      tx_valid_q    <= tx_valid_d;
      seq_err_q     <= seq_err_d;
      tx_hold_q     <= tx_hold_d;
    end
  end

  spi_ram_array u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_addr_q),
    .wdata (rx_data[MEM_WIDTH-1:0]),
    .re    (mem_re),
    .raddr (rd_addr_q),
    .rdata (mem_rdata)
  );

  assign tx_data  = tx_valid_q ? mem_rdata : tx_hold_q;
  assign tx_valid = tx_valid_q;
  assign seq_err  = seq_err_q;

endmodule

// File: tb/tb_spi_ram_mem.sv
// Self-checking bench for spi_ram_mem: reference model plus directed command sequences.
// Honours RAM_AUTO_INC_EN the same way as the design.
module tb_spi_ram_mem;
  import shared_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [MEM_WIDTH+1:0] rx_data = '0;
  logic                 rx_valid = 1'b0;
  logic [MEM_WIDTH-1:0] tx_data;
  logic                 tx_valid;
  logic                 seq_err;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [7:0] m_mem [256];
  int         m_wa, m_ra;
  bit         m_wv, m_rv;
  logic [7:0] e_td;
  bit         e_tv, e_se;
  bit         chk_en = 1'b0;

  spi_ram_mem dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .seq_err  (seq_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wa = 0; m_ra = 0; m_wv = 1'b0; m_rv = 1'b0;
    e_td = 8'h00; e_tv = 1'b0; e_se = 1'b0;
  endtask

  // Apply one cycle of input, then advance the model to what must be visible after the edge.
  task automatic step(input bit v, input logic [1:0] op, input logic [7:0] d);
    rx_valid = v;
    rx_data  = {op, d};
    @(posedge clk);
    e_tv = 1'b0;
    e_se = 1'b0;
    if (v) begin
      case (op)
        2'b00: begin m_wa = d; m_wv = 1'b1; end
        2'b01: begin
          if (m_wv) begin
            m_mem[m_wa] = d;
`ifdef RAM_AUTO_INC_EN
            m_wa = (m_wa + 1) % 256;
`endif
          end else e_se = 1'b1;
        end
        2'b10: begin m_ra = d; m_rv = 1'b1; end
        default: begin
          if (m_rv) begin
            e_td = m_mem[m_ra];
            e_tv = 1'b1;
`ifdef RAM_AUTO_INC_EN
            m_ra = (m_ra + 1) % 256;
`endif
          end else e_se = 1'b1;
        end
      endcase
    end
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_seq_err", {31'h0, seq_err}, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Every-cycle comparison of outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx_valid", {31'h0, tx_valid}, {31'h0, e_tv});
      chk("seq_err", {31'h0, seq_err}, {31'h0, e_se});
      chk("tx_data", {24'h0, tx_data}, {24'h0, e_td});
    end
  end

  initial begin
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // RD_DATA first after reset -> sequence error, no read
    step(1'b1, 2'b11, 8'h00);
    chk("lit_first_rd_seq_err", {31'h0, seq_err}, 32'h1);
    chk("lit_first_rd_tv", {31'h0, tx_valid}, 32'h0);
    step(1'b1, 2'b01, 8'h99);
    chk("lit_first_wr_seq_err", {31'h0, seq_err}, 32'h1);
    step(1'b0, 2'b00, 8'h00);

    // basic write then read back
    step(1'b1, 2'b00, 8'h3C);
    step(1'b1, 2'b01, 8'hA5);
    step(1'b1, 2'b10, 8'h3C);
    step(1'b1, 2'b11, 8'h00);
    chk("lit_rd_3c_tv", {31'h0, tx_valid}, 32'h1);
    chk("lit_rd_3c", {24'h0, tx_data}, 32'hA5);
    step(1'b0, 2'b00, 8'h00);
    chk("lit_rd_3c_pulse", {31'h0, tx_valid}, 32'h0);

    // mid-run reset clears flags; RD_DATA afterwards is a sequence error
    step(1'b1, 2'b10, 8'h3C);
    pulse_reset();
    step(1'b1, 2'b11, 8'h00);
    chk("lit_rd_after_rst", {31'h0, seq_err}, 32'h1);

    // consecutive writes with/without auto increment
    step(1'b1, 2'b00, 8'h10);
    step(1'b1, 2'b01, 8'h11);
    step(1'b1, 2'b01, 8'h22);
    step(1'b1, 2'b10, 8'h10);
    step(1'b1, 2'b11, 8'h00);
`ifdef RAM_AUTO_INC_EN
    chk("lit_seq_first", {24'h0, tx_data}, 32'h11);
`else
    chk("lit_seq_first", {24'h0, tx_data}, 32'h22);
`endif
    step(1'b1, 2'b11, 8'h00);
    chk("lit_seq_second", {24'h0, tx_data}, 32'h22);

    // wrap at top of address space
    step(1'b1, 2'b00, 8'hFF);
    step(1'b1, 2'b01, 8'h77);
    step(1'b1, 2'b01, 8'h88);
`ifdef RAM_AUTO_INC_EN
    step(1'b1, 2'b10, 8'h00);
`else
    step(1'b1, 2'b10, 8'hFF);
`endif
    step(1'b1, 2'b11, 8'h00);
    chk("lit_wrap", {24'h0, tx_data}, 32'h88);

    // read-after-write same address back to back
    step(1'b1, 2'b00, 8'h20);
    step(1'b1, 2'b10, 8'h20);
    step(1'b1, 2'b01, 8'h4E);
    step(1'b1, 2'b11, 8'h00);
    chk("lit_raw", {24'h0, tx_data}, 32'h4E);

    // array contents survive reset; tx_data holds after the pulse
    step(1'b1, 2'b00, 8'h01);
    step(1'b1, 2'b01, 8'h5A);
    pulse_reset();
    step(1'b1, 2'b00, 8'h01);
    step(1'b1, 2'b10, 8'h01);
    step(1'b1, 2'b11, 8'h00);
    chk("lit_retained", {24'h0, tx_data}, 32'h5A);
    step(1'b0, 2'b00, 8'h00);
    step(1'b0, 2'b00, 8'h00);
    chk("lit_hold", {24'h0, tx_data}, 32'h5A);
    chk("lit_hold_tv", {31'h0, tx_valid}, 32'h0);

    // WR_DATA opcode present but rx_valid low -> nothing happens
    step(1'b1, 2'b00, 8'h40);
    step(1'b1, 2'b01, 8'h12);
    for (int i = 0; i < 5; i++) step(1'b0, 2'b01, 8'hEE);
    step(1'b1, 2'b10, 8'h40);
    step(1'b1, 2'b11, 8'h00);
    chk("lit_no_write", {24'h0, tx_data}, 32'h12);
    step(1'b0, 2'b00, 8'h00);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
